// File: rtl/bit_serializer_311.sv
// Parallel-to-serial feeder for the "1011" sequence detector: a small word FIFO
// feeding an MSB-first shifter, with a constant idle bit driven between words.
`timescale 1ns/1ps
module bit_serializer_311 #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                     clk_311,
  input  logic                     rst_311,
  input  logic [WIDTH-1:0]         wr_data_311,
  input  logic                     wr_valid_311,
  output logic                     wr_ready_311,
  input  logic                     flush_311,
  output logic                     ser_out_311,
  output logic                     ser_active_311,
  output logic                     last_bit_311,
  output logic [$clog2(DEPTH):0]   occupancy_311,
  output logic [15:0]              words_sent_311
);

  // state   | meaning
  // S_IDLE  | shifter empty, ser_out_311 = IDLE_BIT
  // S_SHIFT | shifter holds a word, MSB of sr_q on ser_out_311
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       occ_q;
  logic [WIDTH-1:0]  sr_q;
  logic [CW-1:0]     cnt_q;
  logic [15:0]       words_sent_q;
  logic              fifo_empty, cnt_last, word_done, push, pop;

  assign fifo_empty   = (occ_q == '0);
  assign cnt_last     = (cnt_q == CNT_LAST);
  assign wr_ready_311 = (occ_q != OCC_FULL);
  assign word_done    = (state_q == S_SHIFT) && cnt_last;
  assign push         = wr_valid_311 && wr_ready_311 && !flush_311;
  // Pop only sees words pushed at earlier edges: no FIFO bypass.
  assign pop          = !flush_311 && !fifo_empty && ((state_q == S_IDLE) || word_done);

  always_ff @(posedge clk_311 or posedge rst_311) begin
    if (rst_311) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_311) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (!fifo_empty) state_d = S_SHIFT;
        S_SHIFT: if (cnt_last && fifo_empty) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ser_active_311 = (state_q == S_SHIFT);
    ser_out_311    = ser_active_311 ? sr_q[WIDTH-1] : IDLE_BIT;
    last_bit_311   = ser_active_311 && cnt_last;
  end

  always_ff @(posedge clk_311) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_311;
  end

  always_ff @(posedge clk_311 or posedge rst_311) begin
    if (rst_311) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_311) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_311 or posedge rst_311) begin
    if (rst_311) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_311) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (pop) begin
      sr_q  <= mem_q[rd_ptr_q];
      cnt_q <= '0;
    end else if (state_q == S_SHIFT) begin
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
    end
  end

  // A flush on the last bit abandons the word, so it is not counted.
  always_ff @(posedge clk_311 or posedge rst_311) begin
    if (rst_311)                     words_sent_q <= '0;
    else if (word_done && !flush_311) words_sent_q <= words_sent_q + 16'd1;
  end

  assign occupancy_311  = occ_q;
  assign words_sent_311 = words_sent_q;

endmodule

// File: doc/bit_serializer_311.md
Name: bit_serializer_311

Overview:
- Upstream feeder for the team's serial "1011" Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake into a small FIFO and shifts them out MSB-first, one bit per clock, on `ser_out_311`.
- `ser_out_311` connects directly to the detector's `in_311`, and both blocks share `clk_311`/`rst_311`.
- Emits a constant idle bit when no data is queued, so the detector always sees a defined input.

Parameters:
- WIDTH, 8, bits per parallel word (≥2).
- DEPTH, 4, FIFO entries (power of two, ≥2).
- IDLE_BIT, 1'b0, value driven on `ser_out_311` when not shifting.

Ports:
- clk_311  input  1  clock; all state updates on the rising edge.
- rst_311  input  1  reset, asynchronous, active-high.
- wr_data_311  input  WIDTH  parallel word to serialize.
- wr_valid_311  input  1  wr_data_311 is valid.
- wr_ready_311  output  1  FIFO can accept a word (= !full).
- flush_311  input  1  synchronous clear of FIFO and shifter.
- ser_out_311  output  1  serial bit stream to the detector.
- ser_active_311  output  1  ser_out_311 carries a data bit this cycle.
- last_bit_311  output  1  current bit is the LSB of the current word.
- occupancy_311  output  log2(DEPTH)+1  words held in the FIFO (excludes the word in the shifter).
- words_sent_311  output  16  count of fully shifted words; wraps at 16'hFFFF→0.

Behaviour:
- Reset (async, rst_311=1): FIFO empty, rd/wr pointers 0, shifter 0, bit counter 0, state IDLE.
  - Outputs during reset: ser_out_311=IDLE_BIT, ser_active_311=0, last_bit_311=0, wr_ready_311=1, occupancy_311=0, words_sent_311=0.
- Handshake:
  - A word is accepted at a rising edge where wr_valid_311 & wr_ready_311.
  - wr_ready_311 = (occupancy_311 != DEPTH). It does not depend on a same-cycle pop: when full, no push is accepted even if a pop occurs at that edge.
  - wr_data_311 may change freely when not accepted.
- Shifter: WIDTH-bit shift register sr plus bit counter cnt (0..WIDTH-1).
  - ser_out_311 = ser_active_311 ? sr[WIDTH-1] : IDLE_BIT. This is decoded from registers only, with no combinational path from any input.
  - last_bit_311 = ser_active_311 & (cnt==WIDTH-1).
- FSM:
  - IDLE (ser_active=0): at an edge where the FIFO is non-empty, pop the head into sr, set cnt=0 and go to SHIFT.
  - SHIFT (ser_active=1), each edge:
    - If cnt<WIDTH-1: sr<=sr<<1, cnt<=cnt+1.
    - If cnt==WIDTH-1: words_sent_311 increments. Then, if the FIFO is non-empty, pop the next word into sr, cnt<=0 and stay in SHIFT (zero-gap, back-to-back words). Otherwise go to IDLE.
- Latency:
  - A word accepted at edge N into an empty FIFO with the block IDLE moves to the shifter at edge N+1.
  - Its MSB is on ser_out_311 during the cycle after edge N+1.
  - Its LSB is on ser_out_311 during the cycle after edge N+WIDTH.
- The FIFO cannot feed the shifter in the same cycle a word is pushed; there is no bypass path.
- Occupancy:
  - Push only: +1. Pop only: −1. Simultaneous push and pop (possible only when not full): unchanged.
  - Pointers wrap modulo DEPTH.
- flush_311 (synchronous, highest priority after reset):
  - At the edge, FIFO emptied, state→IDLE, cnt=0. A push in the same cycle is discarded.
  - words_sent_311 is not changed, including when the flush falls on the last bit.
  - The detector then sees IDLE_BIT from the next cycle.
- Reset mid-word: the partial word is abandoned. ser_out_311 drops to IDLE_BIT immediately (asynchronous), and all FIFO contents are lost.

Test Plan:
1. After reset, push 8'hB0 once → ser_out_311 = 1,0,1,1,0,0,0,0 on consecutive cycles starting 2 edges after acceptance.
   - last_bit_311 high on the 8th bit only.
   - words_sent_311=1.
   - ser_out_311=0 and ser_active_311=0 afterwards.
2. Push 8'hB5 and 8'h6D on consecutive cycles → 16 contiguous bits 1011_0101_0110_1101 with no idle gap.
   - ser_active_311 high for exactly 16 cycles.
   - words_sent_311=2.
3. Hold wr_valid_311=1 with data 8'h01..8'h06 → the first word enters the shifter, the FIFO reaches occupancy 4 and wr_ready_311=0.
   - The remaining word is accepted only after the next pop.
   - No data is lost or duplicated; the output order is 01..06.
4. Assert rst_311 asynchronously during bit 3 of 8'hFF → ser_out_311=0 immediately.
   - occupancy_311=0, words_sent_311=0.
   - After release, push 8'hB0 → a clean 1011_0000 stream.
5. Queue 3 words, then pulse flush_311 during bit 5 of the first word → next cycle ser_active_311=0, occupancy_311=0, words_sent_311 unchanged.
   - wr_ready_311=1.
6. Preload words_sent_311 to near wrap by streaming 65 536 words of 8'h00 → the count reads 16'hFFFF then 16'h0000 on the following word, and no other output is disturbed.
